forward_pass_sequencer: RTL and testbench

//  Control FSM for one forward pass of the dilated causal conv network. Per sample_clk

---
 rtl/forward_pass_sequencer_if.sv | 30 +++
 rtl/forward_pass_sequencer.sv | 139 +++++++++++++
 tb/tb_forward_pass_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/forward_pass_sequencer_if.sv
// Handshake bundle between the forward-pass sequencer (master) and the conv datapath (slave).
interface forward_pass_sequencer_if #(
  parameter int N_LAYERS = 3,
  parameter int CNT_W    = 16
);
  localparam int CW = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;

  logic [N_LAYERS-1:0] conv_out_v;
  logic                lsb_shift;
  logic [N_LAYERS-1:0] conv_rst;
  logic [CW-1:0]       cache_shift;
  logic                out_latch;
  logic                busy;
  logic [CNT_W-1:0]    pass_count;
  logic [CNT_W-1:0]    overrun_count;
  logic [CNT_W-1:0]    last_latency;
  logic                timeout_err;

  modport master (
    input  conv_out_v,
    output lsb_shift, conv_rst, cache_shift, out_latch, busy,
           pass_count, overrun_count, last_latency, timeout_err
  );

  modport slave (
    output conv_out_v,
    input  lsb_shift, conv_rst, cache_shift, out_latch, busy,
           pass_count, overrun_count, last_latency, timeout_err
  );
endinterface

// File: rtl/forward_pass_sequencer.sv
// Sequences one forward pass per sample_clk rising edge: shift, start/await each conv layer,
// clock the activation caches between layers, then capture the output.
module forward_pass_sequencer #(
  parameter int N_LAYERS = 3,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_clk,
  forward_pass_sequencer_if.master bus
);
  localparam int CW = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;
  localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, START, WAIT, CACHE, OUTPUT} state_t;

  state_t          state, state_n;
  logic [LW-1:0]   lyr, lyr_n;
  logic [WW-1:0]   wcnt, wcnt_n;
  logic            to_set, pass_done;

  // sync[0]=s1, sync[1]=s2, sync[2]=s3; all-ones reset suppresses a tick for a held-high input
  logic [2:0]      sync;
  logic            tick;

  logic                lsb_q, out_q, busy_q, to_q;
  logic [N_LAYERS-1:0] crst_q;
  logic [CW-1:0]       cache_q;
  logic [CNT_W-1:0]    pass_q, ovr_q, lat_q, lat_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) sync <= 3'b111;
    else     sync <= {sync[1:0], sample_clk};
  end

  assign tick = sync[1] & ~sync[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lyr   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      lyr   <= lyr_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    lyr_n     = lyr;
    wcnt_n    = wcnt;
    to_set    = 1'b0;
    pass_done = 1'b0;
    case (state)
      IDLE:   if (tick) state_n = SHIFT;
      SHIFT: begin
        state_n = START;
        lyr_n   = '0;
      end
      START: begin
        state_n = WAIT;
        wcnt_n  = '0;
      end
      WAIT: begin
        if (bus.conv_out_v[lyr]) begin
          state_n = (lyr == LW'(N_LAYERS - 1)) ? OUTPUT : CACHE;
        end else if (wcnt == WW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          to_set  = 1'b1;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      CACHE: begin
        state_n = START;
        lyr_n   = lyr + 1'b1;
      end
      OUTPUT: begin
        state_n   = IDLE;
        pass_done = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each is high exactly while its state is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_q   <= 1'b0;
      crst_q  <= '0;
      cache_q <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      lsb_q   <= (state_n == SHIFT);
      crst_q  <= (state_n == START) ? (N_LAYERS'(1) << lyr_n) : '0;
      cache_q <= (state_n == CACHE) ? (CW'(1) << lyr_n) : '0;
      out_q   <= (state_n == OUTPUT);
      busy_q  <= (state_n != IDLE);
    end
  end

  // lat_cnt holds 1 in IDLE so it reads 1 during SHIFT and the OUTPUT cycle's index at the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt <= '0;
      pass_q  <= '0;
      ovr_q   <= '0;
      lat_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      lat_cnt <= (state == IDLE) ? CNT_W'(1) : sat_inc(lat_cnt);
      if (pass_done) begin
        pass_q <= sat_inc(pass_q);
        lat_q  <= lat_cnt;
      end
      if (tick && state != IDLE) ovr_q <= sat_inc(ovr_q);
      if (to_set) to_q <= 1'b1;
    end
  end

  assign bus.lsb_shift     = lsb_q;
  assign bus.conv_rst      = crst_q;
  assign bus.cache_shift   = cache_q;
  assign bus.out_latch     = out_q;
  assign bus.busy          = busy_q;
  assign bus.pass_count    = pass_q;
  assign bus.overrun_count = ovr_q;
  assign bus.last_latency  = lat_q;
  assign bus.timeout_err   = to_q;
endmodule

// File: tb/tb_forward_pass_sequencer.sv
// Scoreboard bench: a pass-level model predicts strobe order/timing and counters; a monitor checks.
module tb_forward_pass_sequencer;
  localparam int N  = 3;
  localparam int TO = 8;

  typedef struct { int kind; int idx; int ofs; } ev_t;   // kind: 0 shift 1 conv_rst 2 cache 3 out
  typedef struct { int lat; int passes; } lat_t;

  logic clk = 0, rst = 1, sample_clk = 1;
  always #5 clk = ~clk;

  forward_pass_sequencer_if #(.N_LAYERS(N), .CNT_W(16)) bus();

  forward_pass_sequencer #(.N_LAYERS(N), .CNT_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .bus(bus)
  );

  int   n_pass = 0, n_total = 0;
  ev_t  evq[$];
  lat_t latq[$];
  int   exp_pass = 0, exp_ovr = 0, exp_to = 0;
  int   lay_dly[N];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Conv layer stand-in: output valid rises lay_dly[i] WAIT cycles after its start pulse (0 = never).
  int cnt[N];
  initial bus.conv_out_v = '0;
  always @(negedge clk) begin
    if (rst) begin
      bus.conv_out_v = '0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.conv_rst[i]) begin
          bus.conv_out_v[i] = 1'b0;
          cnt[i] = lay_dly[i];
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) bus.conv_out_v[i] = 1'b1;
        end
      end
    end
  end

  // Monitor
  int  cyc = 0, t0 = 0;
  bit  chk_next = 0;
  always @(negedge clk) begin
    int nh;
    ev_t a, e;
    lat_t l;
    cyc++;
    if (!rst) begin
      if (chk_next) begin
        chk_next = 0;
        if (latq.size() == 0) chk("lat_expected", 0, 1);
        else begin
          l = latq.pop_front();
          chk("last_latency", int'(bus.last_latency), l.lat);
          chk("pass_count_after_out", int'(bus.pass_count), l.passes);
        end
      end
      nh = $countones({bus.lsb_shift, bus.conv_rst, bus.cache_shift, bus.out_latch});
      if (nh > 1) chk("strobe_onehot", nh, 1);
      if (nh >= 1) begin
        a.idx = 0;
        if (bus.lsb_shift) begin a.kind = 0; t0 = cyc; end
        else if (|bus.conv_rst) begin
          a.kind = 1;
          for (int i = 0; i < N; i++) if (bus.conv_rst[i]) a.idx = i;
        end else if (|bus.cache_shift) begin
          a.kind = 2;
          for (int i = 0; i < N - 1; i++) if (bus.cache_shift[i]) a.idx = i;
        end else begin a.kind = 3; chk_next = 1; end
        a.ofs = cyc - t0;
        if (evq.size() == 0) chk("strobe_expected", 0, 1);
        else begin
          e = evq.pop_front();
          chk("ev_kind", a.kind, e.kind);
          chk("ev_idx", a.idx, e.idx);
          chk("ev_offset", a.ofs, e.ofs);
        end
      end
    end
  end

  // Pass-level model: each layer costs start + d wait cycles, plus one cache cycle between layers.
  task automatic model_pass(input int d0, input int d1, input int d2);
    int d[N];
    int ofs;
    bit abort;
    lat_t l;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < N; i++) lay_dly[i] = d[i];
    evq.push_back('{0, 0, 0});
    ofs = 1;
    abort = 0;
    for (int i = 0; i < N; i++) begin
      evq.push_back('{1, i, ofs});
      if (d[i] == 0 || d[i] > TO) begin abort = 1; break; end
      ofs = ofs + d[i] + 1;
      if (i < N - 1) begin evq.push_back('{2, i, ofs}); ofs++; end
      else evq.push_back('{3, 0, ofs});
    end
    if (abort) exp_to = 1;
    else begin
      exp_pass++;
      l.lat = ofs + 1;
      l.passes = exp_pass;
      latq.push_back(l);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pass(output bit ok);
    ok = 0;
    sample_clk = 1;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycles(1);
      if (bus.lsb_shift) ok = 1;
    end
    chk("pass_started", ok, 1);
    sample_clk = 0;
  endtask

  task automatic run_pass(input int d0, input int d1, input int d2, input bit ovr);
    bit ok, idle;
    model_pass(d0, d1, d2);
    start_pass(ok);
    cycles(2);
    if (ovr) begin sample_clk = 1; exp_ovr++; end
    idle = 0;
    for (int k = 0; k < 200 && !idle; k++) begin
      cycles(1);
      if (!bus.busy) idle = 1;
    end
    chk("pass_ended", idle, 1);
    sample_clk = 0;
    cycles(3);
    chk("sb_drained", evq.size() + latq.size(), 0);
    chk("pass_count", int'(bus.pass_count), exp_pass);
    chk("overrun_count", int'(bus.overrun_count), exp_ovr);
    chk("timeout_err", int'(bus.timeout_err), exp_to);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < N; i++) lay_dly[i] = 1;
    // reset held with sample_clk high
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_strobes", int'({bus.lsb_shift, bus.conv_rst, bus.cache_shift, bus.out_latch}), 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_counters", int'(bus.pass_count | bus.overrun_count | bus.last_latency), 0);
      chk("rst_timeout_err", bus.timeout_err, 0);
    end
    rst = 0;
    cycles(6);
    chk("no_pass_after_rst", bus.busy, 0);
    sample_clk = 0;
    cycles(3);

    run_pass(1, 1, 1, 0);       // latency 10
    run_pass(5, 5, 5, 0);       // latency 22
    run_pass(1, 1, 1, 1);       // overrun during pass
    run_pass(2, 3, 1, 0);
    run_pass(1, 0, 1, 0);       // layer 1 never valid: timeout
    run_pass(1, 1, 1, 0);       // recovers, timeout_err stays set
    run_pass(TO, 1, TO, 0);     // valid on the last allowed WAIT cycle
    run_pass(1, TO + 1, 1, 1);  // one cycle too late: timeout

    for (int p = 0; p < 20; p++) begin
      int d[N];
      for (int i = 0; i < N; i++) begin
        d[i] = int'($urandom_range(1, TO));
        if ($urandom_range(0, 9) == 0) d[i] = 0;
      end
      run_pass(d[0], d[1], d[2], $urandom_range(0, 2) == 0);
    end

    // reset mid-pass while in WAIT(1)
    model_pass(1, 6, 1);
    start_pass(ok);
    cycles(6);
    rst = 1;
    evq.delete();
    latq.delete();
    exp_pass = 0; exp_ovr = 0; exp_to = 0;
    cycles(1);
    rst = 0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_cache", int'(bus.cache_shift), 0);
    chk("midrst_counters", int'(bus.pass_count | bus.overrun_count | bus.last_latency), 0);
    chk("midrst_timeout_err", bus.timeout_err, 0);
    cycles(12);
    chk("midrst_stays_idle", bus.busy, 0);
    run_pass(1, 2, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
